ad9226_fifo_unpacker: RTL

//  Read side of the ADC sample FIFO. Pops packed FIFO_SIZE-bit sample words.

---
 rtl/ad9226_fifo_unpacker.sv | 137 +++++++++++++
 1 files changed

// File: rtl/ad9226_fifo_unpacker.sv
// ---------------------------------------------------------------------------
// ad9226_fifo_unpacker
//   Read side of the ADC sample FIFO. Pops one packed sample word at a time,
//   serialises it MSB-first into a byte stream for the W5500 socket TX writer
//   and groups WORDS_PER_PACKET words into one packet, flagging the first and
//   last byte of each packet.
//
// Ports
//   sys_clk     in   system clock, rising edge
//   reset_n     in   synchronous active-low reset
//   fifo_empty  in   FIFO empty flag
//   fifo_q      in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  single-cycle FIFO read request
//   byte_ready  in   downstream accepts byte_data this cycle
//   byte_data   out  output byte
//   byte_valid  out  byte_data valid
//   byte_sop    out  first byte of a packet
//   byte_eop    out  last byte of a packet
//   busy        out  high whenever the FSM is not idle
//   pkt_count   out  number of completed packets, wraps to 0
// ---------------------------------------------------------------------------
module ad9226_fifo_unpacker #(
  parameter int FIFO_SIZE        = 240,
  parameter int WORDS_PER_PACKET = 4,
  parameter int PKT_CNT_BITS     = 16
) (
  input  logic                    sys_clk,
  input  logic                    reset_n,
  input  logic                    fifo_empty,
  input  logic [FIFO_SIZE-1:0]    fifo_q,
  output logic                    fifo_rd_en,
  input  logic                    byte_ready,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  output logic                    byte_sop,
  output logic                    byte_eop,
  output logic                    busy,
  output logic [PKT_CNT_BITS-1:0] pkt_count
);

  localparam int BYTES  = FIFO_SIZE / 8;
  localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int WIDX_W = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
  localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
  localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS_PER_PACKET - 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [FIFO_SIZE-1:0] shift_reg;
  logic [BIDX_W-1:0]   byte_idx;
  logic [WIDX_W-1:0]   word_idx;
  logic                xfer;

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and output decode. The read request is also gated by reset_n
  // so that no FIFO entry is popped while the block is being held in reset.
  always_comb begin
    next_state = state;
    fifo_rd_en = 1'b0;
    byte_valid = 1'b0;
    byte_sop   = 1'b0;
    byte_eop   = 1'b0;
    byte_data  = 8'h00;
    busy       = 1'b1;
    xfer       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (!fifo_empty && reset_n) begin
          fifo_rd_en = 1'b1;
          next_state = READ;
        end
      end
      READ: begin
        next_state = SEND;
      end
      SEND: begin
        byte_valid = 1'b1;
        byte_data  = shift_reg[FIFO_SIZE-1 -: 8];
        byte_sop   = (byte_idx == '0) && (word_idx == '0);
        byte_eop   = (byte_idx == LAST_BYTE) && (word_idx == LAST_WORD);
        xfer       = byte_ready;
        if (byte_ready && (byte_idx == LAST_BYTE)) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: the current byte always sits in the top 8 bits of shift_reg,
  // so a completed transfer shifts the next byte into place.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      shift_reg <= '0;
      byte_idx  <= '0;
      word_idx  <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        READ: begin
          shift_reg <= fifo_q;
          byte_idx  <= '0;
        end
        SEND: begin
          if (xfer && (byte_idx != LAST_BYTE)) begin
            shift_reg <= shift_reg << 8;
            byte_idx  <= byte_idx + 1'b1;
          end
        end
        DONE: begin
          if (word_idx == LAST_WORD) begin
            word_idx  <= '0;
            pkt_count <= pkt_count + 1'b1;
          end else begin
            word_idx <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
